// File: rtl/cpu_mem_responder_if.sv
// Load/store bus between the CPU data port and cpu_mem_responder.
// The CPU drives the request side; the responder drives the completion side.
interface cpu_mem_responder_if #(
    parameter int ADDR_WIDTH = 8,
    parameter int DATA_WIDTH = 16
);
    logic                  Req;
    logic                  We;
    logic [ADDR_WIDTH-1:0] Addr;
    logic [DATA_WIDTH-1:0] WData;
    logic                  Ack;
    logic [DATA_WIDTH-1:0] RData;
    logic                  Busy;
    logic [15:0]           TxnCount;

    modport master (
        output Req, We, Addr, WData,
        input  Ack, RData, Busy, TxnCount
    );

    modport slave (
        input  Req, We, Addr, WData,
        output Ack, RData, Busy, TxnCount
    );
endinterface

// File: rtl/cpu_mem_responder.sv
// Word-addressed data memory for the 16-bit CPU: one request at a time,
// a fixed number of wait states, then a one-cycle Ack with registered read data.
module cpu_mem_responder #(
    parameter int ADDR_WIDTH  = 8,
    parameter int DATA_WIDTH  = 16,
    parameter int WAIT_STATES = 2
) (
    input  logic                 Clock,
    input  logic                 Reset,
    cpu_mem_responder_if.slave   bus
);

    localparam int DEPTH = 2 ** ADDR_WIDTH;
    localparam logic [3:0] WAIT_INIT = (WAIT_STATES > 0) ? 4'(WAIT_STATES - 1) : 4'd0;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_WAIT,
        ST_RESP
    } state_t;

    state_t                state_q, state_d;
    logic [3:0]            wait_cnt_q, wait_cnt_d;
    logic                  we_q, we_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
    logic                  ack_q, ack_d;
    logic                  busy_q, busy_d;
    logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
    logic [15:0]           txn_count_q, txn_count_d;

    logic                  acc_we;
    logic [ADDR_WIDTH-1:0] acc_addr;
    logic [DATA_WIDTH-1:0] acc_wdata;
    logic                  enter_resp;
    logic                  mem_wr_en;

    logic [DATA_WIDTH-1:0] mem [DEPTH];

    // With zero wait states the access happens on the acceptance edge itself,
    // so the access fields come straight from the bus instead of the latches.
    always_comb begin
        state_d     = state_q;
        wait_cnt_d  = wait_cnt_q;
        we_d        = we_q;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        rdata_d     = rdata_q;
        txn_count_d = txn_count_q;
        ack_d       = 1'b0;
        acc_we      = we_q;
        acc_addr    = addr_q;
        acc_wdata   = wdata_q;
        enter_resp  = 1'b0;
        mem_wr_en   = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (bus.Req) begin
                    we_d      = bus.We;
                    addr_d    = bus.Addr;
                    wdata_d   = bus.WData;
                    acc_we    = bus.We;
                    acc_addr  = bus.Addr;
                    acc_wdata = bus.WData;
                    if (WAIT_STATES == 0) begin
                        state_d    = ST_RESP;
                        enter_resp = 1'b1;
                    end else begin
                        state_d    = ST_WAIT;
                        wait_cnt_d = WAIT_INIT;
                    end
                end
            end
            ST_WAIT: begin
                if (wait_cnt_q == 4'd0) begin
                    state_d    = ST_RESP;
                    enter_resp = 1'b1;
                end else begin
                    wait_cnt_d = wait_cnt_q - 4'd1;
                end
            end
            ST_RESP: begin
                state_d     = ST_IDLE;
                txn_count_d = txn_count_q + 16'd1;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        if (enter_resp) begin
            ack_d = 1'b1;
            if (acc_we) begin
                mem_wr_en = ~Reset;
            end else begin
                rdata_d = mem[acc_addr];
            end
        end

        busy_d = (state_d != ST_IDLE);
    end

    always_ff @(posedge Clock) begin
        if (Reset) begin
            state_q     <= ST_IDLE;
            wait_cnt_q  <= 4'd0;
            we_q        <= 1'b0;
            addr_q      <= '0;
            wdata_q     <= '0;
            ack_q       <= 1'b0;
            busy_q      <= 1'b0;
            rdata_q     <= '0;
            txn_count_q <= 16'd0;
        end else begin
            state_q     <= state_d;
            wait_cnt_q  <= wait_cnt_d;
            we_q        <= we_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            ack_q       <= ack_d;
            busy_q      <= busy_d;
            rdata_q     <= rdata_d;
            txn_count_q <= txn_count_d;
        end
    end

    // Storage is deliberately left out of reset so it maps onto block/distributed RAM.
    always_ff @(posedge Clock) begin
        if (mem_wr_en) begin
            mem[acc_addr] <= acc_wdata;
        end
    end

    assign bus.Ack      = ack_q;
    assign bus.Busy     = busy_q;
    assign bus.RData    = rdata_q;
    assign bus.TxnCount = txn_count_q;

endmodule

// File: tb/tb_cpu_mem_responder.sv
// Self-checking bench for cpu_mem_responder: three instances (2, 0 and 3 wait
// states) driven by directed steps plus random traffic against a memory model.
module tb_cpu_mem_responder;

    localparam int AW   = 8;
    localparam int DW   = 16;
    localparam int NDUT = 3;
    localparam int WS_TAB [NDUT] = '{2, 0, 3};

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          rst   [NDUT];
    logic          req   [NDUT];
    logic          we    [NDUT];
    logic [AW-1:0] addr  [NDUT];
    logic [DW-1:0] wdata [NDUT];
    logic          ack   [NDUT];
    logic [DW-1:0] rdata [NDUT];
    logic          busy  [NDUT];
    logic [15:0]   cnt   [NDUT];

    for (genvar g = 0; g < NDUT; g++) begin : g_dut
        cpu_mem_responder_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus ();

        assign bus.Req   = req[g];
        assign bus.We    = we[g];
        assign bus.Addr  = addr[g];
        assign bus.WData = wdata[g];
        assign ack[g]    = bus.Ack;
        assign rdata[g]  = bus.RData;
        assign busy[g]   = bus.Busy;
        assign cnt[g]    = bus.TxnCount;

        cpu_mem_responder #(
            .ADDR_WIDTH (AW),
            .DATA_WIDTH (DW),
            .WAIT_STATES(WS_TAB[g])
        ) u_dut (
            .Clock(clk),
            .Reset(rst[g]),
            .bus  (bus)
        );
    end

    // Reference model: what memory holds, what RData should show, how many
    // transactions have completed since the last reset.
    logic [DW-1:0] mem_m     [NDUT][2**AW];
    bit            valid_m   [NDUT][2**AW];
    logic [DW-1:0] exp_rdata [NDUT];
    logic [15:0]   exp_cnt   [NDUT];

    int checks = 0;
    int errors = 0;

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic checkIdle(input int d, input string tag);
        checkOutput({tag, "_ack"},   32'(ack[d]),  32'd0);
        checkOutput({tag, "_busy"},  32'(busy[d]), 32'd0);
        checkOutput({tag, "_rdata"}, 32'(rdata[d]), 32'(exp_rdata[d]));
        checkOutput({tag, "_count"}, 32'(cnt[d]),  32'(exp_cnt[d]));
    endtask

    // Called at a negedge with the DUT idle; that cycle is the acceptance cycle.
    // Returns at the negedge of the IDLE cycle that follows RESP.
    task automatic applyStimulus(input int d, input bit w, input logic [AW-1:0] a,
                                 input logic [DW-1:0] wd, input bit hold, input bit scramble);
        int ws;
        ws       = WS_TAB[d];
        req[d]   = 1'b1;
        we[d]    = w;
        addr[d]  = a;
        wdata[d] = wd;
        if (w) begin
            mem_m[d][a]   = wd;
            valid_m[d][a] = 1'b1;
        end else begin
            exp_rdata[d] = mem_m[d][a];
        end
        for (int k = 1; k <= ws + 1; k++) begin
            @(negedge clk);
            if (!hold) begin
                req[d] = 1'b0;
                if (scramble) begin
                    req[d]   = (k <= ws) ? 1'($urandom_range(0, 1)) : 1'b0;
                    we[d]    = ~w;
                    addr[d]  = ~a;
                    wdata[d] = DW'($urandom);
                end
            end
            checkOutput("busy_in_flight", 32'(busy[d]), 32'd1);
            checkOutput("ack_timing", 32'(ack[d]), 32'(k == ws + 1));
        end
        checkOutput("resp_rdata", 32'(rdata[d]), 32'(exp_rdata[d]));
        checkOutput("resp_count", 32'(cnt[d]),   32'(exp_cnt[d]));
        exp_cnt[d] = exp_cnt[d] + 16'd1;
        @(negedge clk);
        checkIdle(d, "post_resp");
    endtask

    initial begin
        #2_000_000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        for (int d = 0; d < NDUT; d++) begin
            rst[d]       = 1'b1;
            req[d]       = 1'b0;
            we[d]        = 1'b0;
            addr[d]      = '0;
            wdata[d]     = '0;
            exp_rdata[d] = '0;
            exp_cnt[d]   = '0;
        end

        // Reset for two cycles, then ten quiet cycles.
        repeat (2) @(negedge clk);
        for (int d = 0; d < NDUT; d++) rst[d] = 1'b0;
        for (int c = 0; c < 10; c++) begin
            for (int d = 0; d < NDUT; d++) checkIdle(d, "reset_idle");
            @(negedge clk);
        end

        // Write then read back with two wait states.
        applyStimulus(0, 1'b1, 8'h12, 16'hBEEF, 1'b0, 1'b0);
        applyStimulus(0, 1'b0, 8'h12, 16'h0000, 1'b0, 1'b0);
        checkOutput("ws2_readback", 32'(rdata[0]), 32'h0000_BEEF);
        checkOutput("ws2_count",    32'(cnt[0]),   32'd2);

        // Zero wait states with Req held high: one transaction every two cycles.
        applyStimulus(1, 1'b1, 8'h00, 16'h1234, 1'b1, 1'b0);
        applyStimulus(1, 1'b0, 8'h00, 16'h0000, 1'b1, 1'b0);
        req[1] = 1'b0;
        checkOutput("ws0_readback", 32'(rdata[1]), 32'h0000_1234);
        @(negedge clk);
        checkIdle(1, "ws0_no_extra");
        checkOutput("ws0_count", 32'(cnt[1]), 32'd2);

        // Reset in the middle of a write leaves memory and Ack untouched.
        applyStimulus(2, 1'b1, 8'h40, 16'h5555, 1'b0, 1'b0);
        req[2] = 1'b1; we[2] = 1'b1; addr[2] = 8'h40; wdata[2] = 16'hAAAA;
        @(negedge clk);
        req[2] = 1'b0;
        checkOutput("abort_busy_c1", 32'(busy[2]), 32'd1);
        @(negedge clk);
        checkOutput("abort_busy_c2", 32'(busy[2]), 32'd1);
        rst[2] = 1'b1;
        @(negedge clk);
        rst[2] = 1'b0;
        exp_cnt[2]   = '0;
        exp_rdata[2] = '0;
        for (int c = 0; c < 6; c++) begin
            checkIdle(2, "abort_quiet");
            @(negedge clk);
        end
        applyStimulus(2, 1'b0, 8'h40, 16'h0000, 1'b0, 1'b0);
        checkOutput("abort_mem_kept", 32'(rdata[2]), 32'h0000_5555);

        // Request fields changing during WAIT must not affect the access.
        applyStimulus(2, 1'b1, 8'h33, 16'h0F1E, 1'b0, 1'b1);
        applyStimulus(2, 1'b0, 8'h33, 16'h0000, 1'b0, 1'b1);
        checkOutput("stable_readback", 32'(rdata[2]), 32'h0000_0F1E);

        // Transaction counter wraps; RData holds across writes.
        force g_dut[0].u_dut.txn_count_q = 16'hFFFF;
        @(negedge clk);
        release g_dut[0].u_dut.txn_count_q;
        exp_cnt[0] = 16'hFFFF;
        @(negedge clk);
        checkOutput("wrap_preload", 32'(cnt[0]), 32'h0000_FFFF);
        applyStimulus(0, 1'b0, 8'h12, 16'h0000, 1'b0, 1'b0);
        checkOutput("wrap_to_zero", 32'(cnt[0]), 32'd0);
        applyStimulus(0, 1'b1, 8'h55, 16'h7777, 1'b0, 1'b0);
        applyStimulus(0, 1'b1, 8'h56, 16'h8888, 1'b0, 1'b0);
        checkOutput("rdata_held", 32'(rdata[0]), 32'h0000_BEEF);

        // Random traffic over a small address window so reads hit earlier writes.
        for (int d = 0; d < NDUT; d++) begin
            for (int n = 0; n < 25; n++) begin
                logic [AW-1:0] a;
                bit            w;
                a = AW'($urandom_range(0, 15));
                w = 1'($urandom_range(0, 1));
                if (!valid_m[d][a]) w = 1'b1;
                applyStimulus(d, w, a, DW'($urandom), (d == 1) ? 1'($urandom_range(0, 1)) : 1'b0,
                              1'($urandom_range(0, 1)));
            end
            req[d] = 1'b0;
            @(negedge clk);
            checkIdle(d, "random_end");
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
